mips_mc_ctrl: RTL and testbench

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

---
 rtl/mc_pkg.sv | 62 ++++++
 rtl/mc_decode.sv | 29 ++
 rtl/mips_mc_ctrl.sv | 109 ++++++++++
 tb/tb_mips_mc_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared state codes, instruction encodings and datapath select encodings
// for the multi-cycle MIPS controller.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [1:0] NPC_PC4 = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;
    localparam logic [1:0] NPC_JR  = 2'd3;

    localparam logic [1:0] REG_RT = 2'd0;
    localparam logic [1:0] REG_RD = 2'd1;
    localparam logic [1:0] REG_RA = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC4 = 2'd2;

    localparam logic [1:0] EXT_ZERO  = 2'd0;
    localparam logic [1:0] EXT_SIGN  = 2'd1;
    localparam logic [1:0] EXT_UPPER = 2'd2;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;

    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic nop;
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: maps opcode/funct to one-hot instruction-class flags;
// anything unrecognised lands in the nop class.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output iclass_t    cls_o
);

    logic       rtype;
    logic [9:0] hit;

    assign rtype = opcode_i == OP_RTYPE;
    assign hit = {
        rtype && funct_i == FN_ADDU,
        rtype && funct_i == FN_SUBU,
        rtype && funct_i == FN_JR,
        opcode_i == OP_ORI,
        opcode_i == OP_LUI,
        opcode_i == OP_LW,
        opcode_i == OP_SW,
        opcode_i == OP_BEQ,
        opcode_i == OP_J,
        opcode_i == OP_JAL
    };
    assign cls_o = {hit, ~|hit};

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) driving
// shared-memory, PC, register-file and ALU controls.
module mips_mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] npc_sel,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       alu_src,
    output logic [1:0] ext_op,
    output logic [2:0] alu_op,
    output logic [2:0] state
);

    state_e  state_q, state_d;
    iclass_t cls;
    logic    jump, mem_op;

    mc_decode u_decode (
        .opcode_i(opcode),
        .funct_i (funct),
        .cls_o   (cls)
    );

    assign jump   = cls.j | cls.jal | cls.jr;
    assign mem_op = cls.lw | cls.sw;
    assign state  = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        npc_sel = NPC_PC4;
        reg_we  = 1'b0;
        reg_dst = REG_RT;
        wd_sel  = WD_ALU;
        alu_src = 1'b0;
        ext_op  = EXT_ZERO;
        alu_op  = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                pc_we   = jump;
                npc_sel = cls.jr ? NPC_JR : jump ? NPC_J : NPC_PC4;
                reg_we  = cls.jal;
                reg_dst = cls.jal ? REG_RA : REG_RT;
                wd_sel  = cls.jal ? WD_PC4 : WD_ALU;
                state_d = (jump | cls.nop) ? S_FETCH : S_EXEC;
            end
            S_EXEC: begin
                pc_we   = cls.beq & zero;
                npc_sel = cls.beq ? NPC_BR : NPC_PC4;
                alu_op  = cls.beq ? ALU_SUB : ALU_ADD;
                alu_src = mem_op;
                ext_op  = mem_op ? EXT_SIGN : EXT_ZERO;
                state_d = cls.beq ? S_FETCH : mem_op ? S_MEM : S_WB;
            end
            S_MEM: begin
                // address controls stay up for the whole access, including waits
                mem_req = 1'b1;
                mem_we  = cls.sw;
                alu_src = 1'b1;
                ext_op  = EXT_SIGN;
                state_d = !mem_ready ? S_MEM : cls.lw ? S_WB : S_FETCH;
            end
            S_WB: begin
                reg_we  = 1'b1;
                reg_dst = (cls.addu | cls.subu) ? REG_RD : REG_RT;
                wd_sel  = cls.lw ? WD_MEM : WD_ALU;
                alu_src = cls.ori | cls.lui;
                ext_op  = cls.lui ? EXT_UPPER : EXT_ZERO;
                alu_op  = cls.subu ? ALU_SUB : cls.ori ? ALU_OR : cls.lui ? ALU_LUI : ALU_ADD;
            end
            default: state_d = S_FETCH;
        endcase
        // reset silences every strobe immediately, not just from the next edge
        if (reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            reg_we  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: randomized scoreboard bench; per-instruction cycle plans are built
// from the instruction's behaviour and checked cycle by cycle by a monitor.
module tb_mips_mc_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       mreq, mwe, irwe, pcwe;
        logic [1:0] npc;
        logic       rwe;
        logic [1:0] rdst, wd;
        logic       src;
        logic [1:0] ext;
        logic [2:0] alu;
    } obs_t;

    typedef struct packed {
        logic [5:0] op, fn;
        logic       mr, z;
    } stim_t;

    logic       clk = 1'b0, reset = 1'b0;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    logic       zero = 1'b0, mem_ready = 1'b1;
    logic       mem_req, mem_we, ir_we, pc_we, reg_we, alu_src;
    logic [1:0] npc_sel, reg_dst, wd_sel, ext_op;
    logic [2:0] alu_op, state;

    stim_t stim_q[$];
    obs_t  exp_q[$];
    string tag_q[$];
    int    checks = 0, failures = 0, issued = 0, seen = 0, ninstr = 0;
    string names[11] = '{"addu", "subu", "jr", "ori", "lui", "lw", "sw", "beq", "j", "jal", "nop"};

    always #5 clk = ~clk;

    mips_mc_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
        .pc_we(pc_we), .npc_sel(npc_sel), .reg_we(reg_we), .reg_dst(reg_dst),
        .wd_sel(wd_sel), .alu_src(alu_src), .ext_op(ext_op), .alu_op(alu_op), .state(state)
    );

    function automatic obs_t actual();
        return {state, mem_req, mem_we, ir_we, pc_we, npc_sel, reg_we, reg_dst, wd_sel,
                alu_src, ext_op, alu_op};
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%p want=%p", name, got, want);
        end
    endtask

    function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000) return fn == 6'b100001 || fn == 6'b100011 || fn == 6'b001000;
        return op inside {6'b001101, 6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011};
    endfunction

    task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic mr, input logic z,
                        input obs_t e, input string nm);
        stim_q.push_back({op, fn, mr, z});
        exp_q.push_back(e);
        tag_q.push_back(nm);
    endtask

    // k: 0 addu 1 subu 2 jr 3 ori 4 lui 5 lw 6 sw 7 beq 8 j 9 jal 10 nop
    task automatic plan(input int k, input int fw, input int mw, input logic zx);
        logic [5:0] op, fn;
        obs_t       e;
        string      nm;
        fn = 6'($urandom);
        case (k)
            0: begin op = 6'b000000; fn = 6'b100001; end
            1: begin op = 6'b000000; fn = 6'b100011; end
            2: begin op = 6'b000000; fn = 6'b001000; end
            3: op = 6'b001101;
            4: op = 6'b001111;
            5: op = 6'b100011;
            6: op = 6'b101011;
            7: op = 6'b000100;
            8: op = 6'b000010;
            9: op = 6'b000011;
            default: begin
                op = 6'd0; fn = 6'd0;
                if ($urandom_range(0, 1) == 1)
                    do begin op = 6'($urandom); fn = 6'($urandom); end while (legal(op, fn));
            end
        endcase
        nm = $sformatf("%s#%0d", names[k], ninstr++);
        for (int i = 0; i <= fw; i++) begin
            e = '0; e.mreq = 1'b1; e.irwe = (i == fw); e.pcwe = (i == fw);
            push(op, fn, i == fw, 1'($urandom), e, {nm, ".fetch"});
        end
        e = '0; e.st = 3'd1;
        if (k == 2 || k == 8 || k == 9) begin
            e.pcwe = 1'b1; e.npc = (k == 2) ? 2'd3 : 2'd2;
            if (k == 9) begin e.rwe = 1'b1; e.rdst = 2'd2; e.wd = 2'd2; end
        end
        push(op, fn, 1'($urandom), 1'($urandom), e, {nm, ".decode"});
        if (k == 2 || k >= 8) return;
        e = '0; e.st = 3'd2;
        if (k == 7) begin
            e.alu = 3'd1; e.pcwe = zx; e.npc = 2'd1;
            push(op, fn, 1'($urandom), zx, e, {nm, ".exec"});
            return;
        end
        if (k == 5 || k == 6) begin e.src = 1'b1; e.ext = 2'd1; end
        push(op, fn, 1'($urandom), 1'($urandom), e, {nm, ".exec"});
        if (k == 5 || k == 6) begin
            for (int i = 0; i <= mw; i++) begin
                e = '0; e.st = 3'd3; e.mreq = 1'b1; e.mwe = (k == 6); e.src = 1'b1; e.ext = 2'd1;
                push(op, fn, i == mw, 1'($urandom), e, {nm, ".mem"});
            end
            if (k == 6) return;
        end
        e = '0; e.st = 3'd4; e.rwe = 1'b1;
        case (k)
            0: e.rdst = 2'd1;
            1: begin e.rdst = 2'd1; e.alu = 3'd1; end
            3: begin e.src = 1'b1; e.alu = 3'd2; end
            4: begin e.src = 1'b1; e.ext = 2'd2; e.alu = 3'd3; end
            default: e.wd = 2'd1;
        endcase
        push(op, fn, 1'($urandom), 1'($urandom), e, {nm, ".wb"});
    endtask

    task automatic drain();
        int t = 0;
        while ((seen < issued || stim_q.size() > 0) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (seen < issued || stim_q.size() > 0) begin
            failures++;
            $display("FAIL drain_timeout seen=%0d issued=%0d pending=%0d", seen, issued, stim_q.size());
        end
    endtask

    initial begin
        stim_t s;
        forever begin
            @(posedge clk);
            #1;
            if (stim_q.size() > 0) begin
                s = stim_q.pop_front();
                opcode = s.op; funct = s.fn; mem_ready = s.mr; zero = s.z;
                issued++;
            end
        end
    end

    always @(negedge clk) begin
        if (seen < issued) begin
            check(tag_q.pop_front(), actual(), exp_q.pop_front());
            seen++;
        end
    end

    initial begin
        obs_t e;
        #5 reset = 1'b1;
        #5 check("reset_hold", actual(), '0);
        #4;
        plan(0, 0, 0, 1'b0);
        plan(5, 0, 2, 1'b0);
        plan(7, 0, 0, 1'b1);
        plan(7, 0, 0, 1'b0);
        plan(9, 0, 0, 1'b0);
        #3 check("reset_after_edge", actual(), '0);
        #1 reset = 1'b0;
        for (int n = 0; n < 150; n++)
            plan($urandom_range(0, 10), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
        drain();
        #1;
        opcode = 6'b101011; funct = 6'($urandom); mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b0;
        #3;
        e = '0; e.st = 3'd3; e.mreq = 1'b1; e.mwe = 1'b1; e.src = 1'b1; e.ext = 2'd1;
        check("sw_mem_wait", actual(), e);
        reset = 1'b1;
        #1 check("sw_mem_reset", actual(), '0);
        mem_ready = 1'b1;
        @(posedge clk);
        #1 check("reset_over_edge", actual(), '0);
        plan(8, 1, 0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        plan(6, 1, 1, 1'b0);
        plan(10, 0, 0, 1'b0);
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
